// File: rtl/ysyx_23060208_axi_pkg.sv
// Shared AXI-Lite response codes, read-crossbar state encoding and address map.
package ysyx_23060208_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int          XBAR_AW         = 32;
  localparam logic [31:0] CLINT_BASE_DEF  = 32'ha000_0048;
  localparam logic [31:0] CLINT_SIZE_DEF  = 32'h0000_0008;
  localparam logic [31:0] MEM_BASE_DEF    = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE_DEF    = 32'h0800_0000;

  typedef enum logic [1:0] {
    XBAR_IDLE   = 2'd0,
    XBAR_AR_FWD = 2'd1,
    XBAR_R_WAIT = 2'd2,
    XBAR_ERR    = 2'd3
  } xbar_state_e;

endpackage

// File: rtl/ysyx_23060208_xbar_dec.sv
// Address decoder for the read crossbar: picks CLINT (sel=1) or memory (sel=0)
// and flags addresses outside both windows (decerr).
module ysyx_23060208_xbar_dec
  import ysyx_23060208_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = XBAR_AW,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  sel,
  output logic                  decerr
);

  logic [DATA_WIDTH-1:0] clint_off;
  logic [DATA_WIDTH-1:0] mem_off;

  // Offset-then-compare is wrap-safe: addresses below the base wrap to huge offsets.
  assign clint_off = addr - CLINT_BASE;
  assign mem_off   = addr - MEM_BASE;

  assign sel    = clint_off < CLINT_SIZE;
  assign decerr = !sel && !(mem_off < MEM_SIZE);

endmodule

// File: rtl/ysyx_23060208_xbar_rd.sv
// AXI-Lite read crossbar, one master to {s0 = memory, s1 = CLINT}, one read in flight.
// Optional macro XBAR_DECERR_EN: unmapped addresses answer DECERR without touching a slave.
module ysyx_23060208_xbar_rd
  import ysyx_23060208_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = XBAR_AW,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m_araddr,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [DATA_WIDTH-1:0] s0_araddr,
  output logic                  s0_arvalid,
  input  logic                  s0_arready,
  input  logic [DATA_WIDTH-1:0] s0_rdata,
  input  logic [1:0]            s0_rresp,
  input  logic                  s0_rvalid,
  output logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s1_araddr,
  output logic                  s1_arvalid,
  input  logic                  s1_arready,
  input  logic [DATA_WIDTH-1:0] s1_rdata,
  input  logic [1:0]            s1_rresp,
  input  logic                  s1_rvalid,
  output logic                  s1_rready
);

  xbar_state_e           state, state_nxt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  sel_q;
  logic                  dec_sel, dec_decerr;
  logic                  ar_hs;

  logic [1:0]                 s_arready, s_rvalid;
  logic [1:0][DATA_WIDTH-1:0] s_rdata;
  logic [1:0][1:0]            s_rresp;
  logic [1:0]                 s_arvalid_o, s_rready_o;
  logic [1:0][DATA_WIDTH-1:0] s_araddr_o;

  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid  = {s1_rvalid,  s0_rvalid};
  assign s_rdata   = {s1_rdata,   s0_rdata};
  assign s_rresp   = {s1_rresp,   s0_rresp};

  assign s0_arvalid = s_arvalid_o[0];
  assign s1_arvalid = s_arvalid_o[1];
  assign s0_araddr  = s_araddr_o[0];
  assign s1_araddr  = s_araddr_o[1];
  assign s0_rready  = s_rready_o[0];
  assign s1_rready  = s_rready_o[1];

  ysyx_23060208_xbar_dec #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLINT_BASE (CLINT_BASE),
    .CLINT_SIZE (CLINT_SIZE),
    .MEM_BASE   (MEM_BASE),
    .MEM_SIZE   (MEM_SIZE)
  ) u_dec (
    .addr   (m_araddr),
    .sel    (dec_sel),
    .decerr (dec_decerr)
  );

`ifndef XBAR_DECERR_EN
  logic unused_decerr;
  assign unused_decerr = dec_decerr;
`endif

  assign ar_hs = m_arvalid && m_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= XBAR_IDLE;
      addr_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        addr_q <= m_araddr;
        sel_q  <= dec_sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      XBAR_IDLE: begin
        if (m_arvalid) begin
`ifdef XBAR_DECERR_EN
          state_nxt = dec_decerr ? XBAR_ERR : XBAR_AR_FWD;
`else
          state_nxt = XBAR_AR_FWD;
`endif
        end
      end
      XBAR_AR_FWD: if (s_arready[sel_q]) state_nxt = XBAR_R_WAIT;
      XBAR_R_WAIT: if (s_rvalid[sel_q] && m_rready) state_nxt = XBAR_IDLE;
`ifdef XBAR_DECERR_EN
      XBAR_ERR:    if (m_rready) state_nxt = XBAR_IDLE;
`endif
      default:     state_nxt = XBAR_IDLE;
    endcase
  end

  // Outputs are forced low while rst is held so nothing leaks from a dropped read.
  always_comb begin
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    m_rresp     = RESP_OKAY;
    s_arvalid_o = '0;
    s_araddr_o  = '0;
    s_rready_o  = '0;
    if (!rst) begin
      unique case (state)
        XBAR_IDLE: m_arready = 1'b1;
        XBAR_AR_FWD: begin
          s_arvalid_o[sel_q] = 1'b1;
          s_araddr_o[sel_q]  = addr_q;
        end
        XBAR_R_WAIT: begin
          m_rvalid          = s_rvalid[sel_q];
          m_rdata           = s_rdata[sel_q];
          m_rresp           = s_rresp[sel_q];
          s_rready_o[sel_q] = m_rready;
        end
`ifdef XBAR_DECERR_EN
        XBAR_ERR: begin
          m_rvalid = 1'b1;
          m_rresp  = RESP_DECERR;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_xbar_rd.sv
// Scoreboard bench for the read crossbar: randomized master traffic, two
// behavioural slaves, and a monitor checking routing, timing and returned beats.
module tb_ysyx_23060208_xbar_rd;

  localparam logic [31:0] CB = 32'ha000_0048;
  localparam logic [31:0] CS = 32'h0000_0008;
  localparam logic [31:0] MB = 32'h8000_0000;
  localparam logic [31:0] MS = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_araddr = '0;
  logic        m_arvalid = 1'b0;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready = 1'b0;

  logic [31:0] s_araddr [2];
  logic        s_arvalid[2];
  logic        s_arready[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        s_rvalid [2];
  logic        s_rready [2];

  always #5 clk = ~clk;

  ysyx_23060208_xbar_rd dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1])
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; } beat_t;
  typedef struct { int id; logic [31:0] addr; } route_t;

  beat_t  exp_q[$];
  route_t route_q[$];
  int     checks = 0, failures = 0;
  int     ar_force[2] = '{-1, -1};
  int     rr_mode = 0;
  bit     busy = 0, ar_pend = 0;
  int     tgt = 0;
  logic [31:0] cur_a = '0;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Address map as plain ranges: 1 = CLINT, 0 = memory, 2 = decode error.
  function automatic int target(input logic [31:0] a);
    longint unsigned la = 64'(a);
    if (la >= 64'(CB) && la < 64'(CB) + 64'(CS)) return 1;
`ifdef XBAR_DECERR_EN
    if (!(la >= 64'(MB) && la < 64'(MB) + 64'(MS))) return 2;
`endif
    return 0;
  endfunction

  // What each slave answers for an address; id 2 is the crossbar's own DECERR.
  function automatic beat_t slave_beat(input int id, input logic [31:0] a);
    beat_t b;
    if (id == 1) begin
      b.data = 32'h0000_1234 + (a - CB);
      b.resp = 2'b00;
    end else if (id == 0) begin
      b.data = a ^ 32'h5a5a_a5a5;
      b.resp = (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
    end else begin
      b.data = '0;
      b.resp = 2'b11;
    end
    return b;
  endfunction

  task automatic slave_bfm(input int id);
    int ph = 0, cnt = 0;
    logic [31:0] cap = '0, a;
    logic arv, ard, rv, rr, r;
    beat_t b;
    route_t rt;
    s_arready[id] = 0; s_rvalid[id] = 0; s_rdata[id] = '0; s_rresp[id] = '0;
    forever begin
      @(negedge clk);
      arv = s_arvalid[id]; ard = s_arready[id]; a = s_araddr[id];
      rv = s_rvalid[id]; rr = s_rready[id]; r = rst;
      @(posedge clk); #1;
      if (r) begin
        ph = 0; cnt = 0; s_arready[id] = 0; s_rvalid[id] = 0;
        continue;
      end
      case (ph)
        0: begin
          if (arv && ard) begin
            if (route_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL route_unexpected: slave %0d got addr %h expected no request", id, a);
            end else begin
              rt = route_q.pop_front();
              chk32("route_id", 32'(id), 32'(rt.id));
              chk32("route_addr", a, rt.addr);
            end
            cap = a; s_arready[id] = 0; s_rvalid[id] = 0;
            cnt = $urandom_range(0, 3); ph = 1;
          end else if (arv) begin
            s_rvalid[id] = 0;
            if (cnt == 0) s_arready[id] = 1; else cnt--;
          end else begin
            cnt = (ar_force[id] >= 0) ? ar_force[id] : $urandom_range(0, 3);
            // Idle noise on R: the crossbar must ignore it.
            s_rvalid[id] = ($urandom % 3) == 0;
            s_rdata[id]  = $urandom;
            s_rresp[id]  = 2'($urandom);
          end
        end
        1: begin
          if (cnt == 0) begin
            b = slave_beat(id, cap);
            s_rvalid[id] = 1; s_rdata[id] = b.data; s_rresp[id] = b.resp; ph = 2;
          end else cnt--;
        end
        default: begin
          if (rv && rr) begin
            s_rvalid[id] = 0; s_rdata[id] = $urandom; ph = 0;
          end
        end
      endcase
    end
  endtask

  initial slave_bfm(0);
  initial slave_bfm(1);

  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       m_rready = ($urandom % 4) != 0;
      1:       m_rready = 1'b0;
      default: m_rready = 1'b1;
    endcase
  end

  // Monitor: per-cycle protocol checks plus scoreboard pop on each R handshake.
  initial begin
    bit hold = 0;
    logic [31:0] hold_d = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_arready", m_arready, 1'b0);
        chk1("rst_rvalid", m_rvalid, 1'b0);
        chk32("rst_rdata", m_rdata, 32'h0);
        chk32("rst_rresp", 32'(m_rresp), 32'h0);
        for (int i = 0; i < 2; i++) begin
          chk1("rst_s_arvalid", s_arvalid[i], 1'b0);
          chk1("rst_s_rready", s_rready[i], 1'b0);
          chk32("rst_s_araddr", s_araddr[i], 32'h0);
        end
        busy = 0; ar_pend = 0; hold = 0;
        exp_q.delete(); route_q.delete();
      end else begin
        chk1("arready", m_arready, !busy);
        for (int i = 0; i < 2; i++) begin
          chk1("s_arvalid", s_arvalid[i], ar_pend && tgt == i);
          if (ar_pend && tgt == i) chk32("s_araddr", s_araddr[i], cur_a);
          else if (!(busy && tgt == i)) chk32("s_araddr_unsel", s_araddr[i], 32'h0);
          chk1("s_rready", s_rready[i], busy && !ar_pend && tgt == i && m_rready);
        end
        if (!busy || ar_pend) chk1("rvalid_quiet", m_rvalid, 1'b0);
        if (busy && tgt == 2) chk1("rvalid_decerr", m_rvalid, 1'b1);
        if (hold) begin
          chk1("hold_rvalid", m_rvalid, 1'b1);
          chk32("hold_rdata", m_rdata, hold_d);
        end
        hold   = busy && !ar_pend && m_rvalid && !m_rready;
        hold_d = m_rdata;
        if (busy && !ar_pend && m_rvalid && m_rready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected: got rdata %h expected no beat", m_rdata);
          end else begin
            e = exp_q.pop_front();
            chk32("rdata", m_rdata, e.data);
            chk32("rresp", 32'(m_rresp), 32'(e.resp));
          end
          busy = 0;
        end
        if (m_arvalid && m_arready) begin
          busy = 1; tgt = target(m_araddr); cur_a = m_araddr; ar_pend = (tgt != 2);
        end else if (ar_pend && s_arvalid[tgt] && s_arready[tgt]) begin
          ar_pend = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a);
    int n = 0, t;
    bit done = 0;
    m_araddr = a; m_arvalid = 1;
    while (!done) begin
      @(negedge clk);
      if (m_arready) begin
        t = target(a);
        exp_q.push_back(slave_beat(t, a));
        if (t != 2) route_q.push_back('{t, a});
        done = 1;
      end else if (++n > 300) begin
        checks++; failures++;
        $display("FAIL ar_timeout: arready stuck low for addr %h, required a handshake", a);
        done = 1;
      end
      @(posedge clk); #1;
    end
    m_arvalid = 0; m_araddr = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 500) begin
      @(negedge clk); #1;
      if (!busy && exp_q.size() == 0) break;
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0", busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom % 6)
      0:       return CB + 32'(4 * $urandom_range(0, 1));
      1:       return CB + 32'($urandom_range(0, 7));
      2:       return ($urandom % 2) ? CB - 32'd4 : CB + 32'd8;
      3:       return MB + ($urandom & 32'h07ff_fffc);
      4:       return $urandom;
      default: return ($urandom % 2) ? MB + MS - 32'd4 : MB + MS;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    ar_force[1] = 2;
    issue(CB); wait_idle();
    ar_force[1] = -1;
    issue(CB + 32'd4); wait_idle();
    issue(CB + 32'd8); wait_idle();
    issue(CB - 32'd4); wait_idle();

    // Master stalls R for three cycles with data already valid.
    rr_mode = 1;
    issue(MB);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (m_rvalid) break;
      n++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rr_mode = 2;
    wait_idle();

    rr_mode = 0;
    issue(MB + 32'h100);
    issue(CB + 32'd4);
    wait_idle();

    // Reset while waiting on R: the read is dropped.
    rr_mode = 1;
    issue(MB + 32'h40);
    n = 0;
    while (n < 50) begin
      @(negedge clk); #1;
      if (busy && !ar_pend) break;
      n++;
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; rr_mode = 0;
    issue(CB + 32'd4); wait_idle();

    issue(32'h1000_0000); wait_idle();

    for (int i = 0; i < 300; i++) begin
      issue(pick_addr());
      if ($urandom % 3 != 0) wait_idle();
    end
    wait_idle();
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
